// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIT FFT control sequencer: bit-reversed load, then S stages of N/2 butterflies.
// Optional FFT_SEQ_HOLD_EN adds a hold input that freezes the RUN counters.
module fft_stage_sequencer #(
  parameter int N      = 8,
  parameter int PHASES = 3,
  localparam int S  = $clog2(N),
  localparam int AW = $clog2(N),
  localparam int TW = AW - 1,
  localparam int SW = $clog2(S),
  localparam int PW = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef FFT_SEQ_HOLD_EN
  input  logic          hold,
`endif
  input  logic          in_vld,
  output logic          in_rdy,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic [SW-1:0] stage,
  output logic [PW-1:0] phase,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [TW-1:0] tw_idx,
  output logic          bf_en,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [PW-1:0] PLAST = PW'(PHASES - 1);
  localparam logic [TW-1:0] BLAST = TW'(N / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(S - 1);
  localparam logic [AW-1:0] LLAST = AW'(N - 1);

  state_t        st;
  logic [AW-1:0] ld_cnt;
  logic [TW-1:0] bfly;
  logic [SW-1:0] stg;
  logic [PW-1:0] ph;
  logic          hold_i;
  logic          run;
  logic          ph_last;

`ifdef FFT_SEQ_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  assign run     = (st == RUN);
  assign ph_last = (ph == PLAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      ld_cnt <= '0;
      bfly   <= '0;
      stg    <= '0;
      ph     <= '0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            st     <= LOAD;
            ld_cnt <= '0;
          end
        end
        LOAD: begin
          if (in_vld) begin
            if (ld_cnt == LLAST) begin
              st     <= RUN;
              ld_cnt <= '0;
              stg    <= '0;
              bfly   <= '0;
              ph     <= '0;
            end else begin
              ld_cnt <= ld_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (!hold_i) begin
            if (ph_last) begin
              ph <= '0;
              if (bfly == BLAST) begin
                bfly <= '0;
                if (stg == SLAST) begin
                  stg <= '0;
                  st  <= DONE;
                end else begin
                  stg <= stg + 1'b1;
                end
              end else begin
                bfly <= bfly + 1'b1;
              end
            end else begin
              ph <= ph + 1'b1;
            end
          end
        end
        DONE: st <= IDLE;
      endcase
    end
  end

  // mask covers the in-group position; at the last stage it spans all of bfly
  logic [TW-1:0] mask, pos, grp, tw;
  logic [AW-1:0] a, b, rev;

  always_comb begin
    mask = ~({TW{1'b1}} << stg);
    pos  = bfly & mask;
    grp  = bfly >> stg;
    a    = ((AW'(grp) << stg) << 1) | AW'(pos);
    b    = a + (AW'(1) << stg);
    tw   = pos << (SLAST - stg);
    rev  = '0;
    for (int i = 0; i < AW; i++) begin
      rev[i] = ld_cnt[AW-1-i];
    end
  end

  assign in_rdy  = (st == LOAD);
  assign ld_we   = in_vld & in_rdy;
  assign ld_addr = in_rdy ? rev : '0;
  assign busy    = (st == LOAD) || run;
  assign done    = (st == DONE);
  assign stage   = run ? stg : '0;
  assign phase   = run ? ph : '0;
  assign addr_a  = run ? a : '0;
  assign addr_b  = run ? b : '0;
  assign tw_idx  = run ? tw : '0;
  assign bf_en   = run & ph_last & ~hold_i;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: run-index reference model plus literal tables.
// Hold scenario is compiled when FFT_SEQ_HOLD_EN is defined.
module tb_fft_stage_sequencer;
  localparam int N  = 8;
  localparam int P  = 3;
  localparam int S  = 3;
  localparam int NB = N / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_vld = 1'b0;
  logic hold = 1'b0;
  logic       in_rdy, ld_we, bf_en, busy, done;
  logic [2:0] ld_addr, addr_a, addr_b;
  logic [1:0] stage, phase, tw_idx;

  always #5 clk = ~clk;

  fft_stage_sequencer #(.N(N), .PHASES(P)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef FFT_SEQ_HOLD_EN
    .hold(hold),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy), .ld_we(ld_we), .ld_addr(ld_addr),
    .stage(stage), .phase(phase), .addr_a(addr_a), .addr_b(addr_b),
    .tw_idx(tw_idx), .bf_en(bf_en), .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(string nm, int got, int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endfunction

  function automatic int rev3(int x);
    int r = 0;
    for (int i = 0; i < 3; i++) r = r * 2 + ((x >> i) & 1);
    return r;
  endfunction

  // Reference model: mode plus load count and linear RUN cycle index
  typedef enum {M_IDLE, M_LOAD, M_RUN, M_DONE} mmode_t;
  mmode_t mm = M_IDLE;
  int lc = 0;
  int k = 0;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mm = M_IDLE; lc = 0; k = 0; armed = 1'b1;
    end else begin
      case (mm)
        M_IDLE: if (start) begin mm = M_LOAD; lc = 0; end
        M_LOAD: if (in_vld) begin
          if (lc == N - 1) begin mm = M_RUN; k = 0; end
          else lc++;
        end
        M_RUN: if (!hold) begin
          k++;
          if (k == S * NB * P) mm = M_DONE;
        end
        M_DONE: mm = M_IDLE;
      endcase
    end
  end

  int ldq[$];
  int bfq[$];
  int bfi[$];
  int runlen = 0;
  int donecnt = 0;
  int ldcyc = 0;

  always @(negedge clk) begin
    int e_rdy, e_we, e_ld, e_st, e_ph, e_a, e_b, e_tw, e_bf, e_busy, e_done;
    int r, bq, span, pos, grp;
    logic [19:0] ev, av;
    if (armed) begin
      e_rdy = (mm == M_LOAD);
      e_we = e_rdy && in_vld;
      e_ld = e_rdy ? rev3(lc) : 0;
      e_busy = (mm == M_LOAD) || (mm == M_RUN);
      e_done = (mm == M_DONE);
      e_st = 0; e_ph = 0; e_a = 0; e_b = 0; e_tw = 0; e_bf = 0;
      if (mm == M_RUN) begin
        e_st = k / (NB * P);
        r = k % (NB * P);
        bq = r / P;
        e_ph = r % P;
        span = 1 << e_st;
        pos = bq % span;
        grp = bq / span;
        e_a = grp * 2 * span + pos;
        e_b = e_a + span;
        e_tw = pos * (N / (2 * span));
        e_bf = (e_ph == P - 1) && !hold;
      end
      av = {in_rdy, ld_we, ld_addr, stage, phase, addr_a, addr_b,
            tw_idx, bf_en, busy, done};
      ev = {e_rdy[0], e_we[0], 3'(e_ld), 2'(e_st), 2'(e_ph), 3'(e_a),
            3'(e_b), 2'(e_tw), e_bf[0], e_busy[0], e_done[0]};
      n_chk++;
      if (av !== ev) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got %b want %b", $time, av, ev);
      end
      if (ld_we) ldq.push_back(int'(ld_addr));
      if (in_rdy) ldcyc++;
      if (busy && !in_rdy) runlen++;
      if (bf_en) begin
        bfq.push_back(int'(addr_a) * 100 + int'(addr_b) * 10 + int'(tw_idx));
        bfi.push_back(runlen - 1);
      end
      if (done) donecnt++;
    end
  end

  int ld_lit[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int bf_lit[12] = '{10, 230, 450, 670, 20, 132, 460, 572, 40, 151, 262, 373};

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    ldq.delete(); bfq.delete(); bfi.delete();
    runlen = 0; donecnt = 0; ldcyc = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    cyc(1);
  endtask

  task automatic check_ld(string nm);
    chk({nm, "_ld_count"}, ldq.size(), 8);
    for (int j = 0; j < 8 && j < ldq.size(); j++)
      chk($sformatf("%s_ld%0d", nm, j), ldq[j], ld_lit[j]);
  endtask

  task automatic check_bf(string nm);
    chk({nm, "_bf_count"}, bfq.size(), 12);
    for (int j = 0; j < 12 && j < bfq.size(); j++)
      chk($sformatf("%s_bf%0d", nm, j), bfq[j], bf_lit[j]);
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_addr_a", int'(addr_a), 0);
    cyc(10);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", donecnt, 0);

    // full transform, continuous input
    clear();
    pulse_start();
    in_vld = 1'b1;
    wait_done("full");
    in_vld = 1'b0;
    check_ld("full");
    check_bf("full");
    for (int j = 0; j < 12 && j < bfi.size(); j++)
      chk($sformatf("full_bfidx%0d", j), bfi[j], 3 * j + 2);
    chk("full_runlen", runlen, 36);
    chk("full_done", donecnt, 1);

    // load with in_vld toggling
    clear();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      in_vld = (i % 2 == 0);
      cyc(1);
    end
    in_vld = 1'b0;
    wait_done("stall");
    check_ld("stall");
    chk("stall_load_cycles", ldcyc, 15);
    chk("stall_runlen", runlen, 36);
    chk("stall_done", donecnt, 1);

    // start pulses in LOAD, RUN and DONE are ignored
    clear();
    pulse_start();
    in_vld = 1'b1;
    cyc(3);
    pulse_start();
    cyc(10);
    pulse_start();
    cyc(4);
    start = 1'b1;
    wait_done("ign");
    start = 1'b0;
    in_vld = 1'b0;
    cyc(5);
    chk("ign_done", donecnt, 1);
    chk("ign_runlen", runlen, 36);
    chk("ign_bf_count", bfq.size(), 12);
    chk("ign_busy_after", int'(busy), 0);

    // reset during stage 1, then a clean transform
    clear();
    pulse_start();
    in_vld = 1'b1;
    cyc(8);
    cyc(15);
    chk("mid_stage_before_rst", int'(stage), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    in_vld = 1'b0;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_stage", int'(stage), 0);
    chk("mid_rst_done", donecnt, 0);
    clear();
    pulse_start();
    in_vld = 1'b1;
    wait_done("rerun");
    in_vld = 1'b0;
    check_bf("rerun");
    chk("rerun_runlen", runlen, 36);
    chk("rerun_done", donecnt, 1);

`ifdef FFT_SEQ_HOLD_EN
    // hold 5 cycles at stage 1, bfly 2, phase 1
    clear();
    pulse_start();
    in_vld = 1'b1;
    cyc(8);
    cyc(19);
    chk("hold_at_stage", int'(stage), 1);
    chk("hold_at_phase", int'(phase), 1);
    hold = 1'b1;
    cyc(5);
    hold = 1'b0;
    wait_done("hold");
    in_vld = 1'b0;
    check_bf("hold");
    chk("hold_runlen", runlen, 41);
    chk("hold_done", donecnt, 1);
`endif

    cyc(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control sequencer for the in-place radix-2 DIT FFT datapath.
- On a start pulse it loads N input samples into working memory at bit-reversed addresses. It then walks log2(N) stages of N/2 butterflies each.
- Each butterfly is held for PHASES clock cycles, matching the multi-cycle low-power butterfly. The sequencer drives memory addresses, twiddle index, stage index and a commit strobe.
- Sits between the top-level host handshake and the butterfly/memory/twiddle-ROM datapath.

Parameters:
- N, 8, FFT size; power of two, at least 4.
- PHASES, 3, cycles per butterfly; at least 1; commit occurs on the last phase.
- Derived (localparam, not overridable): S = $clog2(N) stages; AW = $clog2(N); TW = AW-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new transform; sampled only in IDLE.
- in_vld  input  1  input sample present on datapath bus.
- in_rdy  output  1  sequencer accepting samples (LOAD state).
- ld_we  output  1  memory write enable for loading = in_vld & in_rdy.
- ld_addr  output  AW  bit-reversed load address.
- stage  output  $clog2(S)  current stage index, 0..S-1.
- phase  output  $clog2(PHASES) (min 1)  phase within current butterfly.
- addr_a  output  AW  butterfly top-leg address.
- addr_b  output  AW  butterfly bottom-leg address.
- tw_idx  output  TW  twiddle ROM index.
- bf_en  output  1  butterfly commit strobe (write-back of both legs).
- busy  output  1  high in LOAD or RUN.
- done  output  1  one-cycle pulse when the transform completes.

Behaviour:
- States are IDLE, LOAD, RUN and DONE, held in a registered state machine. rst forces IDLE from any state, including mid-LOAD or mid-RUN. No partial-result flush is performed.
- Reset and IDLE values: all counters 0. stage, phase, addr_a, addr_b, tw_idx, ld_addr, bf_en, in_rdy, ld_we, busy and done are all 0.
- IDLE:
  - start=1 moves to LOAD on the next edge and clears ld_cnt.
  - start is ignored in every other state.
- LOAD:
  - in_rdy=1.
  - ld_addr = bit-reverse of ld_cnt (AW bits).
  - ld_cnt increments only on cycles where in_vld=1.
  - When ld_cnt==N-1 and in_vld=1, go to RUN. stage, bfly and phase are cleared to 0.
  - in_vld=0 stalls indefinitely with no timeout.
- RUN counters:
  - phase counts 0..PHASES-1 and wraps.
  - On wrap, bfly (0..N/2-1) increments.
  - On bfly wrap, stage increments.
- RUN address generation (combinational from counters, zero added latency):
  - span = 1<<stage, grp = bfly>>stage, pos = bfly & (span-1).
  - addr_a = (grp<<(stage+1)) | pos.
  - addr_b = addr_a + span.
  - tw_idx = pos<<(S-1-stage).
- addr_a, addr_b and tw_idx are stable for all PHASES cycles of a butterfly.
- bf_en = 1 exactly when in RUN and phase==PHASES-1. There is one bf_en per butterfly, N/2*S in total.
- The cycle with stage==S-1, bfly==N/2-1 and phase==PHASES-1 is the last RUN cycle. The next state is DONE.
- RUN duration is exactly S*(N/2)*PHASES cycles.
- DONE: done=1 and busy=0 for one cycle, then IDLE unconditionally. start asserted during DONE is ignored.
- Outputs not meaningful in the current state are driven to 0: addresses and tw_idx outside RUN, ld_addr outside LOAD.
- With PHASES==1, phase is a constant 0 and bf_en is high on every RUN cycle.

Optional Feature:
- Macro: FFT_SEQ_HOLD_EN.
- Defined: adds input port hold (1 bit).
  - While hold=1 in RUN, phase, bfly and stage freeze, bf_en is forced to 0, and addresses stay stable.
  - hold has no effect in IDLE, LOAD or DONE.
  - rst overrides hold.
- Undefined: port absent and behaviour as above. RUN length is fixed at S*(N/2)*PHASES.

Test Plan:
- Reset/idle: assert rst 2 cycles, release -> all outputs 0. Hold start=0 for 10 cycles -> state stays IDLE, busy=0.
- Full transform, N=8, PHASES=3:
  - start pulse, then in_vld=1 continuously -> ld_addr sequence 0,4,2,6,1,5,3,7.
  - Then 36 RUN cycles with bf_en pulses at RUN cycles 2,5,...,35.
  - Stage 0 (a,b) pairs: (0,1),(2,3),(4,5),(6,7), tw 0.
  - Stage 1 pairs: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - Stage 2 pairs: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - done pulses once, on the cycle after the last bf_en.
- Load stall: in_vld toggles 1,0,1,0 during LOAD -> ld_cnt advances only on in_vld=1. ld_we mirrors in_vld. RUN entered after the 8th accepted sample.
- Start ignored: pulse start during LOAD, RUN and DONE -> no restart and no change in counts. Exactly one done per accepted start.
- Reset mid-RUN: assert rst during stage 1 -> next cycle IDLE with all outputs 0. A new start then runs a full clean 36-cycle transform.
- FFT_SEQ_HOLD_EN: hold=1 for 5 cycles at stage 1, bfly 2, phase 1 -> outputs frozen and bf_en=0 throughout. RUN length becomes 41 cycles.
